ex: RTL and testbench

EX -- requirements
Module: ex

---
 rtl/ex_if.sv | 32 +++
 rtl/ex.sv | 222 ++++++++++++++++++++++
 tb/tb_ex.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_if.sv
// EX stage bus bundle.
//   master : pipeline side; drives stall and id_to_ex_bus, observes EX results.
//   slave  : EX stage; consumes stall/id_to_ex_bus, drives MEM/ID buses, data RAM and stall request.
// Bus layouts:
//   id_to_ex_bus  (159) {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr,
//                        sel_rf_res, rdata1, rdata2}
//   ex_to_mem_bus (76)  {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id_bus  (38)  {rf_we, rf_waddr, ex_result}
interface ex_if;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         inst_is_load;
  logic         stallreq_for_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, inst_is_load, stallreq_for_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, inst_is_load, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex.sv
// EX pipeline stage: input register, ALU, HI/LO with MULT/MULTU/MTHI/MTLO/MFHI/MFLO, and an
// optional 32-cycle restoring divider for DIV/DIVU.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ex_if.slave: stall vector in, ID->EX bus in, EX->MEM / EX->ID buses, data RAM
//          controls, inst_is_load and stallreq_for_ex out
// Configuration: define EX_DIV_EN to build the divider; otherwise DIV/DIVU do nothing and
// stallreq_for_ex is tied low.
module ex (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;

  logic [158:0] bus_q, bus_d;
  logic [31:0]  hi_q, hi_d, lo_q, lo_d;

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res,
          rdata1, rdata2} = bus_q;

  logic special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu;
  assign special  = (inst[31:26] == 6'd0);
  assign is_mfhi  = special && (inst[5:0] == FnMfhi);
  assign is_mflo  = special && (inst[5:0] == FnMflo);
  assign is_mthi  = special && (inst[5:0] == FnMthi);
  assign is_mtlo  = special && (inst[5:0] == FnMtlo);
  assign is_mult  = special && (inst[5:0] == FnMult);
  assign is_multu = special && (inst[5:0] == FnMultu);

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], bus.stall[5:4], bus.stall[1:0]};

  // ALU
  logic [31:0] imm_sext, imm_zext, src1, src2, alu_res;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'd0, inst[15:0]};

  always_comb begin
    src1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc) |
           ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
    src2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & imm_sext) |
           ({32{sel_src2[2]}} & 32'd8)  | ({32{sel_src2[3]}} & imm_zext);
    alu_res = 32'd0;
    if (alu_op[11]) alu_res = alu_res | (src1 + src2);
    if (alu_op[10]) alu_res = alu_res | (src1 - src2);
    if (alu_op[9])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[8])  alu_res = alu_res | {31'd0, src1 < src2};
    if (alu_op[7])  alu_res = alu_res | (src1 & src2);
    if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
    if (alu_op[5])  alu_res = alu_res | (src1 | src2);
    if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
    if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
    if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
    if (alu_op[1])  alu_res = alu_res | $unsigned($signed(src2) >>> src1[4:0]);
    if (alu_op[0])  alu_res = alu_res | {inst[15:0], 16'd0};
  end

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
  assign prod_u = {32'd0, rdata1} * {32'd0, rdata2};

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_st_e;

  div_st_e     st_q, st_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;
  logic        is_div, is_divu, div_any, div_sgn;
  logic [31:0] a_mag, b_mag, q_res, r_res;
  logic [32:0] shl, diff;

  assign is_div  = special && (inst[5:0] == 6'h1a);
  assign is_divu = special && (inst[5:0] == 6'h1b);
  assign div_any = is_div || is_divu;
  assign div_sgn = is_div;
  assign a_mag   = (div_sgn && rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
  assign b_mag   = (div_sgn && rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;
  assign shl     = {rem_q, quo_q[31]};
  assign diff    = shl - {1'b0, dvs_q};
  // Divide by zero: the raw iteration leaves quo=all-ones and rem=|dividend|, so only the
  // quotient sign fix-up must be suppressed.
  assign q_res   = dvz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign r_res   = rneg_q ? (~rem_q + 32'd1) : rem_q;

  assign bus.stallreq_for_ex = (st_q == StBusy) || ((st_q == StIdle) && div_any);

  always_comb begin
    st_d   = st_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dvz_d  = dvz_q;
    unique case (st_q)
      StIdle: begin
        if (div_any) begin
          st_d   = StBusy;
          rem_d  = 32'd0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          cnt_d  = 5'd0;
          qneg_d = div_sgn && (rdata1[31] ^ rdata2[31]);
          rneg_d = div_sgn && rdata1[31];
          dvz_d  = (rdata2 == 32'd0);
        end
      end
      StBusy: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shl[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) st_d = StDone;
      end
      StDone: begin
        if (!bus.stall[3]) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end
`else
  assign bus.stallreq_for_ex = 1'b0;
`endif

  // Input register and HI/LO next state
  always_comb begin
    if (!bus.stall[2])      bus_d = bus.id_to_ex_bus;
    else if (!bus.stall[3]) bus_d = '0;
    else                    bus_d = bus_q;

    hi_d = hi_q;
    lo_d = lo_q;
    if (!bus.stall[3]) begin
      if (is_mult)  {hi_d, lo_d} = prod_s;
      if (is_multu) {hi_d, lo_d} = prod_u;
      if (is_mthi)  hi_d = rdata1;
      if (is_mtlo)  lo_d = rdata1;
`ifdef EX_DIV_EN
      if (st_q == StDone) begin
        lo_d = q_res;
        hi_d = r_res;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef EX_DIV_EN
      st_q   <= StIdle;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dvz_q  <= 1'b0;
`endif
    end else begin
      bus_q  <= bus_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
`ifdef EX_DIV_EN
      st_q   <= st_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dvz_q  <= dvz_d;
`endif
    end
  end

  // Outputs; MFHI/MFLO override the write-back fields decoded by ID.
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] ex_result;

  always_comb begin
    rf_we_o    = rf_we;
    rf_waddr_o = rf_waddr;
    ex_result  = alu_res;
    if (is_mfhi || is_mflo) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = inst[15:11];
      ex_result  = is_mfhi ? hi_q : lo_q;
    end
  end

  assign bus.ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_o, rf_waddr_o, ex_result};
  assign bus.ex_to_id_bus    = {rf_we_o, rf_waddr_o, ex_result};
  assign bus.inst_is_load    = ram_en && (ram_wen == 4'b0000);
  assign bus.data_sram_en    = ram_en;
  assign bus.data_sram_wen   = ram_wen;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = rdata2;
endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the EX stage.
module tb_ex;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall_ext;
  int         n_pass = 0;
  int         n_total = 0;

  localparam logic [11:0] OpAdd = 12'h800, OpSub = 12'h400, OpSlt = 12'h200, OpSltu = 12'h100;
  localparam logic [11:0] OpNor = 12'h040, OpOr = 12'h020, OpSrl = 12'h004, OpSra = 12'h002;
  localparam logic [11:0] OpLui = 12'h001;

  ex_if u_if();

  ex u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  // Minimal stall controller: a divider stall request freezes IF/ID/EX and bubbles MEM.
  assign u_if.stall = u_if.stallreq_for_ex ? 6'b001111 : stall_ext;

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] rwen, input logic we,
                                      input logic [4:0] wa, input logic rfres,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, rfres, r1, r2};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rd);
    return {16'd0, rd, 5'd0, funct};
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [158:0] b);
    @(negedge clk);
    u_if.id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic alu_t(input string tag, input logic [11:0] op, input logic [2:0] s1,
                       input logic [3:0] s2, input logic [31:0] inst, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] exp);
    issue(mk(32'd0, inst, op, s1, s2, 1'b0, 4'd0, 1'b1, 5'd2, 1'b0, r1, r2));
    chk(tag, 76'(u_if.ex_to_id_bus), 76'({1'b1, 5'd2, exp}));
  endtask

  task automatic mf_t(input string tag, input logic hi, input logic [4:0] rd,
                      input logic [31:0] exp);
    issue(mk(32'd0, rtype(hi ? 6'h10 : 6'h12, rd), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0,
             5'd0, 1'b0, 32'd0, 32'd0));
    chk(tag, 76'(u_if.ex_to_id_bus), 76'({1'b1, rd, exp}));
  endtask

`ifdef EX_DIV_EN
  task automatic div_t(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    issue(mk(32'd0, rtype(sgn ? 6'h1a : 6'h1b, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0,
             5'd0, 1'b0, a, b));
    // Queued behind the divide; it enters EX on the edge the divide completes.
    u_if.id_to_ex_bus = mk(32'd0, rtype(6'h12, 5'd3), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0,
                           5'd0, 1'b0, 32'd0, 32'd0);
    n = 0;
    while (u_if.stallreq_for_ex && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, " stall cycles"}, 76'(n), 76'd33);
    @(posedge clk);
    #1;
    chk({tag, " lo"}, 76'(u_if.ex_to_id_bus), 76'({1'b1, 5'd3, exp_lo}));
    mf_t({tag, " hi"}, 1'b1, 5'd4, exp_hi);
  endtask
`endif

  initial begin
    rst = 1'b1;
    stall_ext = 6'd0;
    u_if.id_to_ex_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem bus", u_if.ex_to_mem_bus, 76'd0);
    chk("reset id bus", 76'(u_if.ex_to_id_bus), 76'd0);
    chk("reset ctrl", 76'({u_if.inst_is_load, u_if.stallreq_for_ex, u_if.data_sram_en,
                           u_if.data_sram_wen, u_if.data_sram_addr, u_if.data_sram_wdata}), 76'd0);
    @(negedge clk);
    rst = 1'b0;

    // addiu $8, $5, -3
    issue(mk(32'hBFC0_0000, {6'h09, 5'd5, 5'd8, 16'hFFFD}, OpAdd, 3'b001, 4'b0010, 1'b0, 4'd0,
             1'b1, 5'd8, 1'b0, 32'd5, 32'd0));
    chk("addiu fwd", 76'(u_if.ex_to_id_bus), 76'({1'b1, 5'd8, 32'd2}));
    chk("addiu mem", u_if.ex_to_mem_bus,
        {32'hBFC0_0000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd8, 32'd2});

    // Hold with stall[3]=1, then bubble with stall[2]=1, stall[3]=0
    stall_ext = 6'b001100;
    issue(mk(32'h4, 32'h1234_5678, OpOr, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd9, 1'b1,
             32'h1, 32'h2));
    chk("hold", 76'(u_if.ex_to_id_bus), 76'({1'b1, 5'd8, 32'd2}));
    stall_ext = 6'b000100;
    issue(mk(32'h8, 32'h1234_5678, OpOr, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd9, 1'b1,
             32'h1, 32'h2));
    chk("bubble", u_if.ex_to_mem_bus, 76'd0);
    stall_ext = 6'd0;

    // lw $9, 4($4)
    issue(mk(32'h10, {6'h23, 5'd4, 5'd9, 16'd4}, OpAdd, 3'b001, 4'b0010, 1'b1, 4'd0, 1'b1,
             5'd9, 1'b1, 32'h1000, 32'h0));
    chk("lw ram", 76'({u_if.inst_is_load, u_if.data_sram_en, u_if.data_sram_wen,
                       u_if.data_sram_addr}), 76'({1'b1, 1'b1, 4'b0000, 32'h1004}));
    // sw $9, 8($4)
    issue(mk(32'h14, {6'h2B, 5'd4, 5'd9, 16'd8}, OpAdd, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0,
             5'd0, 1'b0, 32'h2000, 32'hDEAD_BEEF));
    chk("sw ram", 76'({u_if.inst_is_load, u_if.data_sram_en, u_if.data_sram_wen,
                       u_if.data_sram_addr, u_if.data_sram_wdata}),
        76'({1'b0, 1'b1, 4'hF, 32'h2008, 32'hDEAD_BEEF}));

    alu_t("sub", OpSub, 3'b001, 4'b0001, 32'h0, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_t("slt", OpSlt, 3'b001, 4'b0001, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_t("sltu", OpSltu, 3'b001, 4'b0001, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_t("sra", OpSra, 3'b100, 4'b0001, {6'd0, 5'd0, 5'd1, 5'd2, 5'd4, 6'h03}, 32'h0,
          32'h8000_0000, 32'hF800_0000);
    alu_t("srl", OpSrl, 3'b100, 4'b0001, {6'd0, 5'd0, 5'd1, 5'd2, 5'd4, 6'h02}, 32'h0,
          32'h8000_0000, 32'h0800_0000);
    alu_t("lui", OpLui, 3'b000, 4'b0000, {6'h0F, 5'd0, 5'd2, 16'h1234}, 32'h0, 32'h0,
          32'h1234_0000);
    alu_t("nor", OpNor, 3'b001, 4'b0001, 32'h0, 32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00);
    alu_t("ori zext", OpOr, 3'b001, 4'b1000, {6'h0D, 5'd1, 5'd2, 16'h8000}, 32'd1, 32'd0,
          32'h0000_8001);
    issue(mk(32'h100, {6'h03, 26'd0}, OpAdd, 3'b010, 4'b0100, 1'b0, 4'd0, 1'b1, 5'd31, 1'b0,
             32'h0, 32'h0));
    chk("jal link", 76'(u_if.ex_to_id_bus), 76'({1'b1, 5'd31, 32'h108}));

    // HI/LO
    issue(mk(32'd0, rtype(6'h18, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'hFFFF_FFFF, 32'd2));
    mf_t("mult hi", 1'b1, 5'd10, 32'hFFFF_FFFF);
    mf_t("mult lo", 1'b0, 5'd11, 32'hFFFF_FFFE);
    issue(mk(32'd0, rtype(6'h19, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'hFFFF_FFFF, 32'd2));
    mf_t("multu hi", 1'b1, 5'd12, 32'd1);
    mf_t("multu lo", 1'b0, 5'd13, 32'hFFFF_FFFE);
    issue(mk(32'd0, rtype(6'h13, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'h1357_9BDF, 32'd0));
    mf_t("mtlo", 1'b0, 5'd14, 32'h1357_9BDF);
    issue(mk(32'd0, rtype(6'h11, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'hA5A5_0000, 32'd0));
    mf_t("mthi", 1'b1, 5'd15, 32'hA5A5_0000);

`ifdef EX_DIV_EN
    div_t("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    div_t("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    // Reset during iteration 10 of a divide
    issue(mk(32'd0, rtype(6'h1b, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'd1000, 32'd3));
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    u_if.id_to_ex_bus = '0;
    @(posedge clk);
    #1;
    chk("rst mid-div stallreq", 76'(u_if.stallreq_for_ex), 76'd0);
    chk("rst mid-div mem bus", u_if.ex_to_mem_bus, 76'd0);
    @(negedge clk);
    rst = 1'b0;
    mf_t("rst hi", 1'b1, 5'd5, 32'd0);
    mf_t("rst lo", 1'b0, 5'd6, 32'd0);
    div_t("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
`else
    // Without the divider DIVU must neither stall nor touch HI/LO.
    issue(mk(32'd0, rtype(6'h1b, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
             32'd100, 32'd7));
    chk("divu no stall", 76'(u_if.stallreq_for_ex), 76'd0);
    mf_t("divu nop hi", 1'b1, 5'd5, 32'hA5A5_0000);
    mf_t("divu nop lo", 1'b0, 5'd6, 32'h1357_9BDF);
    @(negedge clk);
    rst = 1'b1;
    u_if.id_to_ex_bus = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    mf_t("rst hi", 1'b1, 5'd5, 32'd0);
    mf_t("rst lo", 1'b0, 5'd6, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
